// File: rtl/btn_cond_pkg.sv
// btn_cond_pkg: shared FSM state, default debounce length and channel indices for btn_conditioner.
package btn_cond_pkg;
  localparam int DEBOUNCE_DEFAULT = 1_000_000;
  localparam int BTN_OPEN = 0;
  localparam int BTN_CLOSE = 1;
  localparam int BTN_CHANGE = 2;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_e;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel -- 2-flop synchronizer, debounce FSM, registered level/press pulse.
// Optional btn_release pulse when BTN_COND_RELEASE_EN is defined.
module btn_debounce
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
`ifdef BTN_COND_RELEASE_EN
  ,
  output logic btn_release
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
  logic [1:0] sync_q, sync_d;
  btn_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_inc;
  logic level_q, level_d, press_q, press_d, s;
`ifdef BTN_COND_RELEASE_EN
  logic release_q, release_d;
`endif
  always_comb begin
    sync_d = {sync_q[0], btn_raw};
    s = sync_q[1];
    count_inc = (count_q == CMAX) ? CMAX : count_q + 1'b1;
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        state_d = s ? PRESS_WAIT : IDLE;
        count_d = s ? CW'(1) : '0;
      end
      PRESS_WAIT: begin
        state_d = !s ? IDLE : (count_q == CMAX ? HELD : PRESS_WAIT);
        count_d = s ? count_inc : '0;
      end
      HELD: begin
        state_d = s ? HELD : RELEASE_WAIT;
        count_d = s ? '0 : CW'(1);
      end
      RELEASE_WAIT: begin
        state_d = s ? HELD : (count_q == CMAX ? IDLE : RELEASE_WAIT);
        count_d = s ? '0 : count_inc;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    // level_q doubles as "already reported" so a return to HELD never re-pulses
    level_d = (state_q == HELD) || (state_q == RELEASE_WAIT);
    press_d = (state_q == HELD) && !level_q;
`ifdef BTN_COND_RELEASE_EN
    release_d = (state_q == IDLE) && level_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      count_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
`ifdef BTN_COND_RELEASE_EN
      release_q <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      press_q <= press_d;
`ifdef BTN_COND_RELEASE_EN
      release_q <= release_d;
`endif
    end
  end
  assign btn_level = level_q;
  assign btn_press = press_q;
`ifdef BTN_COND_RELEASE_EN
  assign btn_release = release_q;
`endif
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: NUM_BTN independent debounced button channels plus any_press.
// Define BTN_COND_RELEASE_EN to add the btn_release pulse output.
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int NUM_BTN = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic               any_press
`ifdef BTN_COND_RELEASE_EN
  ,
  output logic [NUM_BTN-1:0] btn_release
`endif
);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk(clk),
      .rst(rst),
      .btn_raw(btn_raw[i]),
      .btn_level(btn_level[i]),
      .btn_press(btn_press[i])
`ifdef BTN_COND_RELEASE_EN
      ,
      .btn_release(btn_release[i])
`endif
    );
  end
  assign any_press = |btn_press;
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of btn_conditioner with DEBOUNCE_CYCLES=4, NUM_BTN=3.
module tb_btn_conditioner;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] btn_raw, btn_level, btn_press;
  logic any_press;
`ifdef BTN_COND_RELEASE_EN
  logic [2:0] btn_release;
`endif
  int n_chk = 0, n_fail = 0;
  int t, n_any, a_edge;
  int n_press[3], p_edge[3], l_edge[3], l_low[3], n_rel[3], r_edge[3];
  logic [2:0] a_vec;
  int pat[7] = '{1, 1, 0, 1, 1, 1, 1};

  btn_conditioner #(.NUM_BTN(3), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .any_press(any_press)
`ifdef BTN_COND_RELEASE_EN
    ,
    .btn_release(btn_release)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    t = 0;
    n_any = 0;
    a_edge = -1;
    a_vec = '0;
    for (int c = 0; c < 3; c++) begin
      n_press[c] = 0;
      p_edge[c] = -1;
      l_edge[c] = -1;
      l_low[c] = 0;
      n_rel[c] = 0;
      r_edge[c] = -1;
    end
  endtask

  // edge index t counts from the first edge after clear_obs
  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) begin
        if (btn_press[c]) begin
          if (n_press[c] == 0) p_edge[c] = t;
          n_press[c]++;
        end
        if (btn_level[c]) begin
          if (l_edge[c] < 0) l_edge[c] = t;
        end else l_low[c]++;
`ifdef BTN_COND_RELEASE_EN
        if (btn_release[c]) begin
          if (n_rel[c] == 0) r_edge[c] = t;
          n_rel[c]++;
        end
`endif
      end
      if (any_press) begin
        if (n_any == 0) begin
          a_edge = t;
          a_vec = btn_press;
        end
        n_any++;
      end
      t++;
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_raw = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_level", int'(btn_level), 0);
    check("reset_press", int'(btn_press), 0);
    check("reset_any", int'(any_press), 0);
    rst = 1'b0;
    clear_obs();
    observe(5);
    check("idle_level", l_low[0] + l_low[1] + l_low[2], 15);
    // clean press on channel 0
    btn_raw = 3'b001;
    clear_obs();
    observe(20);
    check("clean_press_edge", p_edge[0], 7);
    check("clean_press_count", n_press[0], 1);
    check("clean_level_edge", l_edge[0], 7);
    check("clean_any_edge", a_edge, 7);
    check("clean_any_count", n_any, 1);
    check("clean_any_vec", int'(a_vec), 1);
    // bouncing channel 1 while channel 0 stays held
    clear_obs();
    for (int j = 0; j < 7; j++) begin
      btn_raw[1] = pat[j][0];
      observe(1);
    end
    observe(15);
    check("bounce_press_edge", p_edge[1], 10);
    check("bounce_press_count", n_press[1], 1);
    check("held_no_repress", n_press[0], 0);
    check("held_level_stays", l_low[0], 0);
    // short release glitch on channel 0
    clear_obs();
    btn_raw[0] = 1'b0;
    observe(2);
    btn_raw[0] = 1'b1;
    observe(15);
    check("glitch_no_press", n_press[0], 0);
    check("glitch_level_stays", l_low[0], 0);
    // release everything
    clear_obs();
    btn_raw = '0;
    observe(15);
    check("release_level", int'(btn_level), 0);
    check("release_no_press", n_any, 0);
    check("release_level_drop", l_low[0], 8);
`ifdef BTN_COND_RELEASE_EN
    check("release_edge0", r_edge[0], 7);
    check("release_count0", n_rel[0], 1);
    check("release_edge1", r_edge[1], 7);
    check("release_count2", n_rel[2], 0);
`endif
    // simultaneous press on channels 0 and 2
    clear_obs();
    btn_raw = 3'b101;
    observe(12);
    check("simul_vec", int'(a_vec), 5);
    check("simul_any_count", n_any, 1);
    check("simul_edge0", p_edge[0], 7);
    check("simul_edge2", p_edge[2], 7);
    check("simul_ch1_quiet", n_press[1], 0);
    btn_raw = '0;
    observe(15);
    // reset in the middle of a debounce, button still held
    btn_raw = 3'b100;
    clear_obs();
    observe(4);
    check("pre_reset_no_press", n_press[2], 0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("in_reset_level", int'(btn_level), 0);
      check("in_reset_press", int'(btn_press), 0);
      check("in_reset_any", int'(any_press), 0);
    end
    rst = 1'b0;
    clear_obs();
    observe(12);
    check("post_reset_edge", p_edge[2], 7);
    check("post_reset_count", n_press[2], 1);
    observe(40);
    check("saturate_single_press", n_press[2], 1);
    check("saturate_level", int'(btn_level), 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
